regfile_wb_sink: RTL and testbench
==================================

Name: regfile_wb_sink

Overview:
- Architectural integer register file: 32 x DATA_WIDTH.
- Write port is the consumer end of the writeback path: it takes wb_write_data plus RegWrite/rd from the MEM/WB register and commits on the clock edge.
- Two combinational read ports feed the ID stage, with write-to-read bypass so a same-cycle WB write is visible to ID.
- A registered debug read port and a commit counter support testbench and trace checking.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- NUM_REGS, 32, number of architectural registers; must be a power of two.
- ADDR_WIDTH, 5, register address width; must equal log2(NUM_REGS).
- CNT_WIDTH, 32, width of the commit counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- mem_wb_RegWrite  in  1  write enable from the MEM/WB register.
- mem_wb_rd  in  ADDR_WIDTH  destination register address.
- wb_write_data  in  DATA_WIDTH  write data selected by the WB stage.
- id_rs1_addr  in  ADDR_WIDTH  read port 1 address.
- id_rs2_addr  in  ADDR_WIDTH  read port 2 address.
- id_rs1_data  out  DATA_WIDTH  read port 1 data (combinational).
- id_rs2_data  out  DATA_WIDTH  read port 2 data (combinational).
- dbg_req  in  1  debug read request, single-cycle, accepted every cycle.
- dbg_addr  in  ADDR_WIDTH  debug read address.
- dbg_valid  out  1  debug response valid, registered.
- dbg_data  out  DATA_WIDTH  debug response data, registered.
- wb_commit_count  out  CNT_WIDTH  count of committed non-x0 writes.

Behaviour:
- Reset (rst=1 at posedge):
  - All registers, dbg_valid, dbg_data and wb_commit_count are cleared to 0.
  - Any write presented in that cycle is discarded.
  - Reset mid-stream has the same effect, with no partial commit.
- Reads while rst=1: id_rs1_data and id_rs2_data return the stored value (0 after the first reset edge), and bypass is suppressed.
- Write condition: commit occurs at posedge when rst=0, mem_wb_RegWrite=1 and mem_wb_rd!=0; the value committed is regs[mem_wb_rd] <= wb_write_data.
- x0:
  - Always reads 0.
  - Writes to x0 are dropped, are not bypassed and are not counted.
- Read ports, combinational, zero latency. For each port p:
  - If addr_p==0, output 0.
  - Otherwise, if a write condition holds and mem_wb_rd==addr_p, output wb_write_data (write-first bypass).
  - Otherwise, output regs[addr_p].
- Both read ports may address the same register. Both must return identical data, including when bypassed.
- Debug port:
  - When dbg_req=1 at posedge (rst=0), the next cycle shows dbg_valid=1 and dbg_data = the value the read-port logic would return for dbg_addr in the request cycle. This includes bypass of a same-cycle write.
  - Otherwise dbg_valid=0 and dbg_data holds its previous value.
  - Latency is exactly 1 cycle.
  - Back-to-back requests give back-to-back responses, in order, with no stall and no ready signal.
- wb_commit_count:
  - Increments by 1 on each committed write; wraps modulo 2^CNT_WIDTH with no saturation.
  - Holds when RegWrite=0 or rd=0.
- Out-of-range addresses cannot occur because NUM_REGS = 2^ADDR_WIDTH.
- No X propagation: all storage is reset, and outputs are defined from the first post-reset cycle.

Test Plan:
1. Reset then read all: assert rst 1 cycle; sweep rs1/rs2 over 0..31 -> every read returns 0x00000000; wb_commit_count=0; dbg_valid=0.
2. Write then read: write x5=0xDEADBEEF. The same cycle shows id_rs1_data=0xDEADBEEF (bypass) with rs1=5. Next cycle, RegWrite=0 and rs2=5 -> id_rs2_data=0xDEADBEEF; count=1.
3. x0 protection: RegWrite=1, rd=0, data=0x12345678 with rs1=0 -> id_rs1_data=0 in that cycle and the next; count unchanged.
4. Debug back-to-back:
   - Pre-load x1=0x11 and x2=0x22.
   - Cycle N: dbg_req=1, addr=1. Cycle N+1: dbg_req=1, addr=2, while writing x2=0x99.
   - Expected: dbg_valid=1 with dbg_data=0x11 at N+1, then dbg_valid=1 with dbg_data=0x99 at N+2, then dbg_valid=0 at N+3.
5. Reset mid-operation: write x7=0xA5A5A5A5 in the same cycle rst=1 -> after the edge x7 reads 0, count=0, and bypass is not seen during the rst cycle.
6. Counter wrap (CNT_WIDTH=4 build): 17 committed writes to x3 -> wb_commit_count=1; interleaved RegWrite=0 cycles leave it unchanged.

Source files
------------

// File: rtl/regfile_wb_sink_if.sv
// Writeback, ID read and debug signals of the architectural register file.
// The master modport is the pipeline/bench side; the slave is the register file.
interface regfile_wb_sink_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
);
    logic                  mem_wb_RegWrite;
    logic [ADDR_WIDTH-1:0] mem_wb_rd;
    logic [DATA_WIDTH-1:0] wb_write_data;
    logic [ADDR_WIDTH-1:0] id_rs1_addr;
    logic [ADDR_WIDTH-1:0] id_rs2_addr;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic                  dbg_req;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic                  dbg_valid;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic [CNT_WIDTH-1:0]  wb_commit_count;

    modport master (
        output mem_wb_RegWrite, mem_wb_rd, wb_write_data,
        output id_rs1_addr, id_rs2_addr, dbg_req, dbg_addr,
        input  id_rs1_data, id_rs2_data, dbg_valid, dbg_data, wb_commit_count
    );

    modport slave (
        input  mem_wb_RegWrite, mem_wb_rd, wb_write_data,
        input  id_rs1_addr, id_rs2_addr, dbg_req, dbg_addr,
        output id_rs1_data, id_rs2_data, dbg_valid, dbg_data, wb_commit_count
    );
endinterface

// File: rtl/regfile_wb_sink.sv
// Architectural register file at the end of the writeback path: write-first
// bypassed combinational ID reads, a 1-cycle debug read port and a commit counter.
module regfile_wb_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic clk,
    input  logic rst,
    regfile_wb_sink_if.slave bus
);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] rs1_s;
    logic [DATA_WIDTH-1:0] rs2_s;
    logic [DATA_WIDTH-1:0] dbg_rd_s;
    logic                  dbg_valid_r;
    logic [DATA_WIDTH-1:0] dbg_data_r;
    logic [CNT_WIDTH-1:0]  count_r;

    // x0 reads as zero regardless of storage; a live write wins over stored data.
    function automatic logic [DATA_WIDTH-1:0] read_mux(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  wen,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] res;
        if (addr == {ADDR_WIDTH{1'b0}}) begin
            res = {DATA_WIDTH{1'b0}};
        end else if (wen && (waddr == addr)) begin
            res = wdata;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Commit qualifier: suppressed in reset and for x0, which also gates bypass.
    always_comb begin
        wr_en_s = 1'b0;
        if (!rst && bus.mem_wb_RegWrite && (bus.mem_wb_rd != {ADDR_WIDTH{1'b0}})) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Read-port muxes shared by both ID ports and the debug port.
    always_comb begin
        rs1_s    = read_mux(bus.id_rs1_addr, wr_en_s, bus.mem_wb_rd, bus.wb_write_data,
                            regs_r[bus.id_rs1_addr]);
        rs2_s    = read_mux(bus.id_rs2_addr, wr_en_s, bus.mem_wb_rd, bus.wb_write_data,
                            regs_r[bus.id_rs2_addr]);
        dbg_rd_s = read_mux(bus.dbg_addr, wr_en_s, bus.mem_wb_rd, bus.wb_write_data,
                            regs_r[bus.dbg_addr]);
    end

    // Register storage: full clear on reset, single committed write otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[bus.mem_wb_rd] <= bus.wb_write_data;
        end
    end

    // Debug response: one-cycle pulse per request, data held between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_valid_r <= 1'b0;
            dbg_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (bus.dbg_req) begin
            dbg_valid_r <= 1'b1;
            dbg_data_r  <= dbg_rd_s;
        end else begin
            dbg_valid_r <= 1'b0;
        end
    end

    // Commit counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (wr_en_s) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.id_rs1_data     = rs1_s;
    assign bus.id_rs2_data     = rs2_s;
    assign bus.dbg_valid       = dbg_valid_r;
    assign bus.dbg_data        = dbg_data_r;
    assign bus.wb_commit_count = count_r;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Randomized and directed bench for regfile_wb_sink against an array-based model;
// a second instance with a 4-bit counter shares the same stimulus to exercise wrap.
module tb_regfile_wb_sink;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_sink_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) bus ();
    regfile_wb_sink_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4))  bus4 ();

    regfile_wb_sink #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .CNT_WIDTH(32))
        dut (.clk(clk), .rst(rst), .bus(bus));
    regfile_wb_sink #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .CNT_WIDTH(4))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.mem_wb_RegWrite = bus.mem_wb_RegWrite;
    assign bus4.mem_wb_rd       = bus.mem_wb_rd;
    assign bus4.wb_write_data   = bus.wb_write_data;
    assign bus4.id_rs1_addr     = bus.id_rs1_addr;
    assign bus4.id_rs2_addr     = bus.id_rs2_addr;
    assign bus4.dbg_req         = bus.dbg_req;
    assign bus4.dbg_addr        = bus.dbg_addr;

    // Reference model state
    logic [31:0]       mregs [32];
    longint unsigned   mcnt;
    logic              mdv;
    logic [31:0]       mdd;
    logic              model_valid = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (!rst && bus.mem_wb_RegWrite && bus.mem_wb_rd != 5'd0 && bus.mem_wb_rd == addr)
            return bus.wb_write_data;
        return mregs[addr];
    endfunction

    task automatic apply(input logic r, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                         input logic dq, input logic [4:0] da);
        rst                 = r;
        bus.mem_wb_RegWrite = we;
        bus.mem_wb_rd       = rd;
        bus.wb_write_data   = wd;
        bus.id_rs1_addr     = a1;
        bus.id_rs2_addr     = a2;
        bus.dbg_req         = dq;
        bus.dbg_addr        = da;
    endtask

    // Advance one clock and update the model with what was sampled at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mcnt = 0;
            mdv = 1'b0;
            mdd = 32'd0;
            model_valid = 1'b1;
        end else begin
            if (bus.dbg_req) begin
                mdd = exp_read(bus.dbg_addr);
                mdv = 1'b1;
            end else begin
                mdv = 1'b0;
            end
            if (bus.mem_wb_RegWrite && bus.mem_wb_rd != 5'd0) begin
                mregs[bus.mem_wb_rd] = bus.wb_write_data;
                mcnt = mcnt + 1;
            end
        end
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("rs1", {32'd0, bus.id_rs1_data}, {32'd0, exp_read(bus.id_rs1_addr)});
            chk("rs2", {32'd0, bus.id_rs2_data}, {32'd0, exp_read(bus.id_rs2_addr)});
            chk("dbg_valid", {63'd0, bus.dbg_valid}, {63'd0, mdv});
            chk("dbg_data", {32'd0, bus.dbg_data}, {32'd0, mdd});
            chk("count32", {32'd0, bus.wb_commit_count}, {32'd0, mcnt[31:0]});
            chk("count4", {60'd0, bus4.wb_commit_count}, {60'd0, mcnt[3:0]});
            chk("rs1_dut4", {32'd0, bus4.id_rs1_data}, {32'd0, exp_read(bus.id_rs1_addr)});
        end
    end

    initial begin
        logic [4:0] rd, a1, a2;
        apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        tick();

        // Reset then read all
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 5'd0);
            #1;
            chk("t1_rs1", {32'd0, bus.id_rs1_data}, 64'd0);
            chk("t1_rs2", {32'd0, bus.id_rs2_data}, 64'd0);
            tick();
        end
        chk("t1_count", {32'd0, bus.wb_commit_count}, 64'd0);
        chk("t1_dbg_valid", {63'd0, bus.dbg_valid}, 64'd0);

        // Write then read with same-cycle bypass
        apply(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0);
        #1;
        chk("t2_bypass", {32'd0, bus.id_rs1_data}, 64'hDEADBEEF);
        tick();
        apply(1'b0, 1'b0, 5'd5, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0);
        #1;
        chk("t2_stored", {32'd0, bus.id_rs2_data}, 64'hDEADBEEF);
        chk("t2_count", {32'd0, bus.wb_commit_count}, 64'd1);

        // x0 protection
        apply(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        chk("t3_x0_same", {32'd0, bus.id_rs1_data}, 64'd0);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        chk("t3_x0_next", {32'd0, bus.id_rs1_data}, 64'd0);
        chk("t3_count", {32'd0, bus.wb_commit_count}, 64'd1);

        // Debug back-to-back with bypass on the second request
        apply(1'b0, 1'b1, 5'd1, 32'h11, 5'd0, 5'd0, 1'b0, 5'd0); tick();
        apply(1'b0, 1'b1, 5'd2, 32'h22, 5'd0, 5'd0, 1'b0, 5'd0); tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd1); tick();
        apply(1'b0, 1'b1, 5'd2, 32'h99, 5'd0, 5'd0, 1'b1, 5'd2);
        #1;
        chk("t4_n1_valid", {63'd0, bus.dbg_valid}, 64'd1);
        chk("t4_n1_data", {32'd0, bus.dbg_data}, 64'h11);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        #1;
        chk("t4_n2_valid", {63'd0, bus.dbg_valid}, 64'd1);
        chk("t4_n2_data", {32'd0, bus.dbg_data}, 64'h99);
        tick();
        chk("t4_n3_valid", {63'd0, bus.dbg_valid}, 64'd0);
        chk("t4_n3_hold", {32'd0, bus.dbg_data}, 64'h99);

        // Reset mid-operation: stored value visible, write neither bypassed nor kept
        apply(1'b0, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0, 1'b0, 5'd0); tick();
        apply(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b1, 5'd7);
        #1;
        chk("t5_no_bypass", {32'd0, bus.id_rs1_data}, 64'h77);
        tick();
        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd2, 1'b0, 5'd0);
        #1;
        chk("t5_x7", {32'd0, bus.id_rs1_data}, 64'd0);
        chk("t5_x2", {32'd0, bus.id_rs2_data}, 64'd0);
        chk("t5_count", {32'd0, bus.wb_commit_count}, 64'd0);
        chk("t5_dbg_valid", {63'd0, bus.dbg_valid}, 64'd0);
        tick();

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            apply(1'b0, 1'b1, 5'd3, 32'(i), 5'd3, 5'd0, 1'b0, 5'd0); tick();
            apply(1'b0, 1'b0, 5'd3, 32'hFFFF, 5'd3, 5'd0, 1'b0, 5'd0); tick();
            if (i == 15) chk("t6_wrap0", {60'd0, bus4.wb_commit_count}, 64'd0);
        end
        chk("t6_count4", {60'd0, bus4.wb_commit_count}, 64'd1);
        chk("t6_count32", {32'd0, bus.wb_commit_count}, 64'd17);
        chk("t6_x3", {32'd0, bus.id_rs1_data}, 64'd16);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), rd, $urandom,
                  a1, a2, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 31)));
            tick();
        end

        apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
